instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first PC fetched after reset.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before fault (8-bit counter, 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_stall  input  1  inhibits issue of a new fetch.
REQ-006 SHALL have port i_branch_valid  input  1  one-cycle redirect request.
REQ-007 SHALL have port i_branch_target  input  32  redirect address.
REQ-008 SHALL have port o_fetch_enable  output  1  fetch-stage start pulse.
REQ-009 SHALL have port o_fetch_pc  output  32  address for fetch stage.
REQ-010 SHALL have port i_fetch_instruction  input  32  word returned by fetch stage.
REQ-011 SHALL have port i_fetch_completed  input  1  one-cycle completion pulse from fetch stage.
REQ-012 SHALL have port o_instr  output  32  instruction to decode.
REQ-013 SHALL have port o_instr_pc  output  32  address of o_instr.
REQ-014 SHALL have port o_instr_valid  output  1  o_instr/o_instr_pc valid.
REQ-015 SHALL have port i_instr_ready  input  1  decode accepts instruction.
REQ-016 SHALL have port o_fault  output  1  sticky fetch timeout flag.

Function
REQ-017 SHALL implement states IDLE, REQUEST, WAIT, HOLD, FAULT.
REQ-018 SHALL keep registers pc (next fetch address) and req_pc (in-flight address); o_fetch_pc = req_pc.
REQ-019 IDLE: if !i_stall, req_pc<=pc, go REQUEST; else remain.
REQ-020 REQUEST: o_fetch_enable=1 for exactly this one cycle; clear timeout counter; go WAIT.
REQ-021 o_fetch_enable SHALL be 0 in every other state; req_pc stable from REQUEST through WAIT.
REQ-022 WAIT, i_fetch_completed and no flush pending: o_instr<=i_fetch_instruction, o_instr_pc<=req_pc, o_instr_valid<=1, pc<=req_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go HOLD.
REQ-023 WAIT, i_fetch_completed with flush pending: discard word, clear flush, o_instr_valid stays 0, go IDLE.
REQ-024 WAIT, no completion: counter increments; on reaching TIMEOUT, set o_fault, go FAULT.
REQ-025 HOLD: o_instr, o_instr_pc, o_instr_valid held stable until i_instr_ready=1.
REQ-026 HOLD with i_instr_ready: o_instr_valid<=0; go REQUEST (req_pc<=pc) if !i_stall, else IDLE; zero-bubble back-to-back issue.
REQ-027 Branch target SHALL be word-aligned: bits [1:0] forced to 0 when loaded.
REQ-028 Branch in IDLE: pc<=target.
REQ-029 Branch in REQUEST or WAIT: pc<=target, set flush pending; in-flight fetch still completes and is discarded per REQ-023.
REQ-030 Branch in HOLD: pc<=target, o_instr_valid<=0, go IDLE; if i_instr_ready same cycle, transfer counts as accepted.
REQ-031 Branch takes priority over i_fetch_completed in same cycle: completed word discarded, go IDLE, no flush left pending.
REQ-032 FAULT: terminal; all outputs except o_fault held at reset values; inputs ignored until reset.
REQ-033 At most one fetch outstanding; i_fetch_completed outside WAIT SHALL be ignored.

Reset
REQ-034 reset=0 SHALL immediately (asynchronously) force state IDLE, pc=RESET_PC, req_pc=RESET_PC, flush=0, counter=0.
REQ-035 During reset: o_fetch_enable=0, o_instr=0, o_instr_pc=0, o_instr_valid=0, o_fault=0.
REQ-036 Reset mid-WAIT SHALL abandon the fetch; a late completion after release is ignored (state IDLE).
REQ-037 First o_fetch_enable SHALL occur no earlier than second rising edge after reset release.

Verification
REQ-038 Linear: RESET_PC=0, no stall, ready=1, completion 3 cycles after each enable -> fetch PCs 0,4,8; o_instr_pc 0,4,8 with returned words, one valid cycle each.
REQ-039 Backpressure: ready=0 for 5 cycles in HOLD -> o_instr/o_instr_pc/valid stable, no o_fetch_enable until ready=1.
REQ-040 Branch in WAIT to 32'h0000_1003 -> old word never valid; next o_fetch_pc=32'h0000_1000.
REQ-041 Branch and completion same cycle -> word discarded, next fetch at target.
REQ-042 Wrap: pc=32'hFFFF_FFFC fetched -> next o_fetch_pc=0.
REQ-043 Timeout: TIMEOUT=4, no completion -> o_fault=1 after 4 WAIT cycles, stays 1, no further enables; reset clears.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches one word at a time, delivers it to decode through a valid/ready hold stage.
// A fetch issues one cycle after leaving IDLE; back-to-back issue is bubble-free; decode backpressure holds HOLD.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_target,
  output logic        o_fetch_enable,
  output logic [31:0] o_fetch_pc,
  input  logic [31:0] i_fetch_instruction,
  input  logic        i_fetch_completed,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] req_pc, req_pc_nx;
  logic [31:0] instr_nx, instr_pc_nx;
  logic        valid_nx, fault_nx;
  logic        flush, flush_nx;
  logic [7:0]  cnt, cnt_nx, cnt_inc;
  logic [31:0] tgt;

  assign tgt        = i_branch_target & 32'hFFFF_FFFC;
  assign cnt_inc    = cnt + 8'd1;
  assign o_fetch_pc = req_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      req_pc        <= RESET_PC;
      flush         <= 1'b0;
      cnt           <= 8'd0;
      o_instr       <= 32'd0;
      o_instr_pc    <= 32'd0;
      o_instr_valid <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      req_pc        <= req_pc_nx;
      flush         <= flush_nx;
      cnt           <= cnt_nx;
      o_instr       <= instr_nx;
      o_instr_pc    <= instr_pc_nx;
      o_instr_valid <= valid_nx;
      o_fault       <= fault_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    req_pc_nx      = req_pc;
    flush_nx       = flush;
    cnt_nx         = cnt;
    instr_nx       = o_instr;
    instr_pc_nx    = o_instr_pc;
    valid_nx       = o_instr_valid;
    fault_nx       = o_fault;
    o_fetch_enable = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_branch_valid) pc_nx = tgt;
        // A redirect arriving with the issue decision fetches the target directly.
        if (!i_stall) begin
          req_pc_nx = i_branch_valid ? tgt : pc;
          state_nx  = S_REQUEST;
        end
      end

      S_REQUEST: begin
        o_fetch_enable = 1'b1;
        cnt_nx         = 8'd0;
        state_nx       = S_WAIT;
        if (i_branch_valid) begin
          pc_nx    = tgt;
          flush_nx = 1'b1;
        end
      end

      S_WAIT: begin
        if (i_fetch_completed) begin
          if (i_branch_valid || flush) begin
            if (i_branch_valid) pc_nx = tgt;
            flush_nx = 1'b0;
            state_nx = S_IDLE;
          end else begin
            instr_nx    = i_fetch_instruction;
            instr_pc_nx = req_pc;
            valid_nx    = 1'b1;
            pc_nx       = req_pc + 32'd4;
            state_nx    = S_HOLD;
          end
        end else begin
          if (i_branch_valid) begin
            pc_nx    = tgt;
            flush_nx = 1'b1;
          end
          cnt_nx = cnt_inc;
          // Fault parks every other output at its reset value.
          if (cnt_inc == TIMEOUT) begin
            fault_nx    = 1'b1;
            flush_nx    = 1'b0;
            req_pc_nx   = RESET_PC;
            instr_nx    = 32'd0;
            instr_pc_nx = 32'd0;
            state_nx    = S_FAULT;
          end
        end
      end

      S_HOLD: begin
        if (i_branch_valid) begin
          pc_nx    = tgt;
          valid_nx = 1'b0;
          state_nx = S_IDLE;
        end else if (i_instr_ready) begin
          valid_nx = 1'b0;
          if (!i_stall) begin
            req_pc_nx = pc;
            state_nx  = S_REQUEST;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end

      S_FAULT: begin
        state_nx = S_FAULT;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, reset corner cases, then randomized traffic vs a transaction model.
module tb_instr_sequencer;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] W1  = 32'h1111_0001;
  localparam logic [31:0] W2  = 32'h2222_0002;
  localparam logic [31:0] W3  = 32'h3333_0003;
  localparam logic [31:0] W4  = 32'h4444_0004;
  localparam logic [31:0] W5  = 32'h5555_0005;
  localparam logic [31:0] W6  = 32'h6666_0006;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_branch_valid = 1'b0;
  logic [31:0] i_branch_target = 32'h0;
  logic        o_fetch_enable;
  logic [31:0] o_fetch_pc;
  logic [31:0] i_fetch_instruction = 32'h0;
  logic        i_fetch_completed = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic        o_fault;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(8'd4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_stall             (i_stall),
    .i_branch_valid      (i_branch_valid),
    .i_branch_target     (i_branch_target),
    .o_fetch_enable      (o_fetch_enable),
    .o_fetch_pc          (o_fetch_pc),
    .i_fetch_instruction (i_fetch_instruction),
    .i_fetch_completed   (i_fetch_completed),
    .o_instr             (o_instr),
    .o_instr_pc          (o_instr_pc),
    .o_instr_valid       (o_instr_valid),
    .i_instr_ready       (i_instr_ready),
    .o_fault             (o_fault)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        comp;
    logic [31:0] word;
    logic        rdy;
    logic        en;
    logic [31:0] fpc;
    logic        v;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic        flt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic c,
                     input logic [31:0] w, input logic r, input logic en, input logic [31:0] fpc,
                     input logic v, input logic [31:0] ins, input logic [31:0] ipc, input logic flt);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.comp = c; x.word = w; x.rdy = r;
    x.en = en; x.fpc = fpc; x.v = v; x.ins = ins; x.ipc = ipc; x.flt = flt;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic c,
                       input logic [31:0] w, input logic r);
    i_stall = s; i_branch_valid = b; i_branch_target = t;
    i_fetch_completed = c; i_fetch_instruction = w; i_instr_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(L0, L0, Z, L0, Z, L0);
    #1;
    chk1("rst fetch_enable", o_fetch_enable, L0);
    chk1("rst instr_valid", o_instr_valid, L0);
    chk1("rst fault", o_fault, L0);
    chk("rst instr", o_instr, Z);
    chk("rst instr_pc", o_instr_pc, Z);
    chk("rst fetch_pc", o_fetch_pc, Z);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        outst, poison, just, have, go, exp_en;
    logic        s, r, b, c, idle;
    logic [31:0] t, w, exp_pc, out_pc, it_ins, it_pc;
    int          due;

    // Rows: inputs for the next edge, then outputs expected after that edge.
    add(L0,L0,Z,L0,Z,L1,              L1,Z,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,Z,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,Z,L0,Z,Z,L0);
    add(L0,L0,Z,L1,W1,L1,             L0,Z,L1,W1,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'h4,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'h4,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'h4,L0,Z,Z,L0);
    add(L0,L0,Z,L1,W2,L1,             L0,32'h4,L1,W2,32'h4,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'h8,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'h8,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'h8,L0,Z,Z,L0);
    add(L0,L0,Z,L1,W3,L1,             L0,32'h8,L1,W3,32'h8,L0);
    for (int i = 0; i < 5; i++)
      add(L0,L0,Z,L0,Z,L0,            L0,32'h8,L1,W3,32'h8,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'hC,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'hC,L0,Z,Z,L0);
    add(L0,L1,32'h1003,L0,Z,L1,       L0,32'hC,L0,Z,Z,L0);
    add(L0,L0,Z,L1,BAD,L1,            L0,32'hC,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'h1000,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'h1000,L0,Z,Z,L0);
    add(L0,L1,32'hFFFF_FFFC,L1,BAD,L1,L0,32'h1000,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'hFFFF_FFFC,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'hFFFF_FFFC,L0,Z,Z,L0);
    add(L0,L0,Z,L1,W4,L1,             L0,32'hFFFF_FFFC,L1,W4,32'hFFFF_FFFC,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,Z,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,Z,L0,Z,Z,L0);
    add(L0,L0,Z,L1,W5,L1,             L0,Z,L1,W5,Z,L0);
    add(L1,L0,Z,L0,Z,L1,              L0,Z,L0,Z,Z,L0);
    add(L1,L0,Z,L0,Z,L1,              L0,Z,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'h4,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,32'h4,L0,Z,Z,L0);
    add(L0,L0,Z,L1,W6,L1,             L0,32'h4,L1,W6,32'h4,L0);
    add(L0,L1,32'h2000,L0,Z,L1,       L0,32'h4,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L1,32'h2000,L0,Z,Z,L0);
    add(L0,L0,Z,L1,BAD,L1,            L0,32'h2000,L0,Z,Z,L0);
    for (int i = 0; i < 3; i++)
      add(L0,L0,Z,L0,Z,L1,            L0,32'h2000,L0,Z,Z,L0);
    add(L0,L0,Z,L0,Z,L1,              L0,Z,L0,Z,Z,L1);
    add(L0,L0,Z,L1,BAD,L1,            L0,Z,L0,Z,Z,L1);
    add(L0,L1,32'h3000,L0,Z,L1,       L0,Z,L0,Z,Z,L1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].comp, tbl[i].word, tbl[i].rdy);
      @(negedge clk);
      chk1($sformatf("row%0d fetch_enable", i), o_fetch_enable, tbl[i].en);
      chk($sformatf("row%0d fetch_pc", i), o_fetch_pc, tbl[i].fpc);
      chk1($sformatf("row%0d instr_valid", i), o_instr_valid, tbl[i].v);
      chk1($sformatf("row%0d fault", i), o_fault, tbl[i].flt);
      if (tbl[i].v || tbl[i].flt) begin
        chk($sformatf("row%0d instr", i), o_instr, tbl[i].ins);
        chk($sformatf("row%0d instr_pc", i), o_instr_pc, tbl[i].ipc);
      end
    end

    // Reset during WAIT abandons the fetch; a late completion must be ignored.
    do_reset();
    drive(L0, L0, Z, L0, Z, L1);
    @(negedge clk);
    chk1("midwait first enable", o_fetch_enable, L1);
    chk("midwait first pc", o_fetch_pc, Z);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("midwait rst enable", o_fetch_enable, L0);
    chk1("midwait rst valid", o_instr_valid, L0);
    @(negedge clk);
    reset = 1'b1;
    drive(L1, L0, Z, L1, BAD, L1);
    @(negedge clk);
    chk1("late completion valid", o_instr_valid, L0);
    chk1("late completion enable", o_fetch_enable, L0);
    drive(L0, L0, Z, L0, Z, L1);
    @(negedge clk);
    chk1("restart enable", o_fetch_enable, L1);
    chk("restart pc", o_fetch_pc, Z);

    // Randomized traffic against a transaction-level model.
    do_reset();
    outst = 0; poison = 0; just = 0; have = 0; exp_en = 0;
    exp_pc = 32'h0; out_pc = 32'h0; it_ins = 32'h0; it_pc = 32'h0; due = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk1("rnd fetch_enable", o_fetch_enable, exp_en);
      if (exp_en) begin
        chk("rnd fetch_pc", o_fetch_pc, exp_pc);
        outst  = 1;
        poison = 0;
        just   = 1;
        out_pc = exp_pc;
        due    = $urandom_range(1, 4);
      end else begin
        just = 0;
      end
      chk1("rnd instr_valid", o_instr_valid, have);
      if (have) begin
        chk("rnd instr", o_instr, it_ins);
        chk("rnd instr_pc", o_instr_pc, it_pc);
      end
      chk1("rnd fault", o_fault, L0);

      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1);
      b = ($urandom_range(0, 15) == 0);
      t = $urandom;
      w = $urandom;
      c = 0;
      if (outst && !just) begin
        if (due == 1) c = 1;
        due--;
      end else if (!outst && $urandom_range(0, 7) == 0) begin
        c = 1;
      end
      drive(s, b, t, c, w, r);

      idle = !outst && !have;
      go   = !s && (idle || (have && r && !b));
      if (have && (r || b)) have = 0;
      if (c && outst && !just) begin
        outst = 0;
        if (!b && !poison) begin
          have   = 1;
          it_ins = w;
          it_pc  = out_pc;
          exp_pc = out_pc + 32'd4;
        end
      end
      if (b) begin
        exp_pc = t & 32'hFFFF_FFFC;
        if (outst) poison = 1;
      end
      exp_en = go;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
